// File: rtl/gpio_io_controller_if.sv
// gpio_io_controller_if: CPU-side request/response bundle for the gpio I/O sequencer
interface gpio_io_controller_if;
    logic       req;
    logic [1:0] op;
    logic [5:0] io_addr;
    logic [7:0] wr_data;
    logic [2:0] bit_sel;
    logic       busy;
    logic       ack;
    logic       addr_err;
    logic [7:0] rd_data;
    modport master (output req, op, io_addr, wr_data, bit_sel, input busy, ack, addr_err, rd_data);
    modport slave  (input req, op, io_addr, wr_data, bit_sel, output busy, ack, addr_err, rd_data);
endinterface

// File: rtl/gpio_io_controller.sv
// gpio_io_controller: sequences IN/OUT/SBI/CBI I/O accesses onto the gpio register block
module gpio_io_controller #(
    parameter logic [5:0] ADDR_PINB  = 6'h16,
    parameter logic [5:0] ADDR_DDRB  = 6'h17,
    parameter logic [5:0] ADDR_PORTB = 6'h18,
    parameter logic [5:0] ADDR_PINA  = 6'h19,
    parameter logic [5:0] ADDR_DDRA  = 6'h1A,
    parameter logic [5:0] ADDR_PORTA = 6'h1B
) (
    input  logic       clk,
    input  logic       clr_n,
    gpio_io_controller_if.slave bus,
    output logic [7:0] gpio_wdata,
    output logic       DDRA_we,
    output logic       PORTA_we,
    output logic       DDRB_we,
    output logic       PORTB_we,
    input  logic [7:0] DDRA_q,
    input  logic [7:0] PORTA_q,
    input  logic [7:0] PINA_q,
    input  logic [7:0] DDRB_q,
    input  logic [7:0] PORTB_q,
    input  logic [7:0] PINB_q
);
    typedef enum logic [1:0] {IDLE, EXEC, RMW, DONE} state_t;
    localparam logic [1:0] OP_IN  = 2'b00;
    localparam logic [1:0] OP_OUT = 2'b01;
    state_t     state, state_nx;
    logic [1:0] op_q;
    logic [5:0] addr_q;
    logic [7:0] wdata_q, tmp, rd_q, sel_q, mask;
    logic [2:0] bit_q;
    logic       err_q, mapped, wr_cycle;
    // address decode and read mux over the latched address
    always_comb begin
        mapped = addr_q == ADDR_PINB || addr_q == ADDR_DDRB || addr_q == ADDR_PORTB ||
                 addr_q == ADDR_PINA || addr_q == ADDR_DDRA || addr_q == ADDR_PORTA;
        sel_q  = addr_q == ADDR_PINB  ? PINB_q  :
                 addr_q == ADDR_DDRB  ? DDRB_q  :
                 addr_q == ADDR_PORTB ? PORTB_q :
                 addr_q == ADDR_PINA  ? PINA_q  :
                 addr_q == ADDR_DDRA  ? DDRA_q  :
                 addr_q == ADDR_PORTA ? PORTA_q : 8'h00;
    end
    // next state; set/clear go through RMW only for mapped addresses
    always_comb begin
        state_nx = state == IDLE ? (bus.req ? EXEC : IDLE) :
                   state == EXEC ? (mapped && op_q[1] ? RMW : DONE) :
                   state == RMW  ? DONE : IDLE;
    end
    // Moore outputs from state and latched fields only; PINx has no enable so writes to it vanish
    always_comb begin
        mask       = 8'd1 << bit_q;
        wr_cycle   = (state == EXEC && mapped && op_q == OP_OUT) || state == RMW;
        gpio_wdata = state == RMW ? (op_q[0] ? tmp & ~mask : tmp | mask) :
                     (state == EXEC && op_q == OP_OUT) ? wdata_q : 8'h00;
        DDRA_we    = wr_cycle && addr_q == ADDR_DDRA;
        PORTA_we   = wr_cycle && addr_q == ADDR_PORTA;
        DDRB_we    = wr_cycle && addr_q == ADDR_DDRB;
        PORTB_we   = wr_cycle && addr_q == ADDR_PORTB;
        bus.busy     = state != IDLE;
        bus.ack      = state == DONE;
        bus.addr_err = err_q;
        bus.rd_data  = rd_q;
    end
    // state register, request latch, read result and read-modify-write capture
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= IDLE;
            op_q    <= 2'b00;
            addr_q  <= 6'h00;
            wdata_q <= 8'h00;
            bit_q   <= 3'd0;
            tmp     <= 8'h00;
            rd_q    <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.req) begin
                op_q    <= bus.op;
                addr_q  <= bus.io_addr;
                wdata_q <= bus.wr_data;
                bit_q   <= bus.bit_sel;
                err_q   <= 1'b0;
            end
            if (state == EXEC) begin
                tmp <= sel_q;
                if (!mapped) err_q <= 1'b1;
                else if (op_q == OP_IN) rd_q <= sel_q;
            end
        end
    end
endmodule

// File: tb/tb_gpio_io_controller.sv
// tb_gpio_io_controller: directed checks of the gpio I/O sequencer
module tb_gpio_io_controller;
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic [7:0] gpio_wdata;
    logic DDRA_we, PORTA_we, DDRB_we, PORTB_we;
    logic [7:0] DDRA_q = 8'h00, PORTA_q = 8'h00, PINA_q = 8'h00;
    logic [7:0] DDRB_q = 8'h00, PORTB_q = 8'h00, PINB_q = 8'h00;
    int total = 0, bad = 0, we_cnt = 0, multi = 0, ack_cnt = 0, lat, ok;
    logic [3:0] we_mask;
    logic [7:0] last_wd;
    logic [3:0] we_vec;

    gpio_io_controller_if bus();

    gpio_io_controller dut (
        .clk(clk), .clr_n(clr_n), .bus(bus), .gpio_wdata(gpio_wdata),
        .DDRA_we(DDRA_we), .PORTA_we(PORTA_we), .DDRB_we(DDRB_we), .PORTB_we(PORTB_we),
        .DDRA_q(DDRA_q), .PORTA_q(PORTA_q), .PINA_q(PINA_q),
        .DDRB_q(DDRB_q), .PORTB_q(PORTB_q), .PINB_q(PINB_q)
    );

    always #5 clk = ~clk;

    assign we_vec = {DDRA_we, PORTA_we, DDRB_we, PORTB_we};

    // record write-enable pulses and acks once per cycle
    always @(negedge clk) begin
        if (we_vec != 4'b0000) begin
            we_cnt += $countones(we_vec);
            we_mask = we_vec;
            last_wd = gpio_wdata;
        end
        if ($countones(we_vec) > 1) multi++;
        if (bus.ack) ack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one transaction; inputs are scrambled after the sampling edge, lat = edges to ack (0 = timeout)
    task automatic run(input logic [1:0] op, input logic [5:0] a, input logic [7:0] d,
                       input logic [2:0] b, output int l);
        @(negedge clk);
        we_cnt = 0; we_mask = 4'b0000; last_wd = 8'h00;
        bus.req = 1'b1; bus.op = op; bus.io_addr = a; bus.wr_data = d; bus.bit_sel = b;
        @(posedge clk);
        #1;
        bus.req = 1'b0; bus.op = ~op; bus.io_addr = 6'h1A; bus.wr_data = ~d; bus.bit_sel = ~b;
        l = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (bus.ack) begin
                l = n;
                break;
            end
            @(posedge clk);
        end
    endtask

    logic [1:0] b_op [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [5:0] b_ad [4] = '{6'h1B, 6'h19, 6'h18, 6'h1A};
    logic [7:0] b_wd [4] = '{8'h11, 8'h00, 8'h00, 8'h00};
    logic [2:0] b_bt [4] = '{3'd0, 3'd0, 3'd4, 3'd0};

    initial begin
        bus.req = 1'b0; bus.op = 2'b00; bus.io_addr = 6'h00; bus.wr_data = 8'h00; bus.bit_sel = 3'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_rd", bus.rd_data, 8'h00);
        check("rst_wd", gpio_wdata, 8'h00);
        check("rst_we", we_vec, 4'b0000);
        clr_n = 1'b1;

        run(2'b01, 6'h1B, 8'hA5, 3'd0, lat);
        check("out_lat", lat, 2);
        check("out_we_cnt", we_cnt, 1);
        check("out_we_mask", we_mask, 4'b0100);
        check("out_wd", last_wd, 8'hA5);
        check("out_err", bus.addr_err, 0);

        PINA_q = 8'h3C;
        run(2'b00, 6'h19, 8'h77, 3'd0, lat);
        check("in_lat", lat, 2);
        check("in_rd", bus.rd_data, 8'h3C);
        check("in_we_cnt", we_cnt, 0);
        run(2'b01, 6'h1A, 8'h55, 3'd0, lat);
        check("out2_we_mask", we_mask, 4'b1000);
        check("out2_wd", last_wd, 8'h55);
        check("out2_rd_hold", bus.rd_data, 8'h3C);

        PORTB_q = 8'h0F;
        run(2'b10, 6'h18, 8'h00, 3'd7, lat);
        check("sbi_lat", lat, 3);
        check("sbi_we_mask", we_mask, 4'b0001);
        check("sbi_wd", last_wd, 8'h8F);
        PORTB_q = 8'h8F;
        run(2'b11, 6'h18, 8'h00, 3'd0, lat);
        check("cbi_lat", lat, 3);
        check("cbi_we_cnt", we_cnt, 1);
        check("cbi_wd", last_wd, 8'h8E);

        run(2'b00, 6'h20, 8'h00, 3'd0, lat);
        check("unm_lat", lat, 2);
        check("unm_err", bus.addr_err, 1);
        check("unm_rd", bus.rd_data, 8'h3C);
        check("unm_we_cnt", we_cnt, 0);
        run(2'b01, 6'h16, 8'hFF, 3'd0, lat);
        check("pinb_out_lat", lat, 2);
        check("pinb_out_err", bus.addr_err, 0);
        check("pinb_out_we", we_cnt, 0);
        run(2'b10, 6'h19, 8'h00, 3'd2, lat);
        check("pina_sbi_lat", lat, 3);
        check("pina_sbi_err", bus.addr_err, 0);
        check("pina_sbi_we", we_cnt, 0);

        DDRB_q = 8'h99;
        run(2'b00, 6'h17, 8'h00, 3'd0, lat);
        check("in_ddrb_rd", bus.rd_data, 8'h99);
        PORTA_q = 8'h42;
        run(2'b00, 6'h1B, 8'h00, 3'd0, lat);
        check("in_porta_rd", bus.rd_data, 8'h42);

        @(negedge clk);
        bus.req = 1'b1; bus.op = 2'b10; bus.io_addr = 6'h18; bus.bit_sel = 3'd1;
        @(posedge clk);
        #1 bus.req = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rmw_we", PORTB_we, 1);
        clr_n = 1'b0;
        #1;
        check("mid_rst_we", we_vec, 4'b0000);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_rd", bus.rd_data, 8'h00);
        check("mid_rst_wd", gpio_wdata, 8'h00);
        @(negedge clk);
        check("mid_rst_hold_we", we_vec, 4'b0000);
        clr_n = 1'b1;

        PORTB_q = 8'h8F;
        DDRA_q = 8'h03;
        @(negedge clk);
        ack_cnt = 0; we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            bus.req = 1'b1; bus.op = b_op[i]; bus.io_addr = b_ad[i];
            bus.wr_data = b_wd[i]; bus.bit_sel = b_bt[i];
            ok = 0;
            for (int n = 0; n < 6; n++) begin
                @(negedge clk);
                if (bus.busy) begin
                    ok = 1;
                    break;
                end
            end
            check("b2b_start", ok, 1);
            bus.op = ~b_op[i]; bus.io_addr = 6'h18; bus.wr_data = 8'hFF; bus.bit_sel = ~b_bt[i];
            ok = 0;
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                if (bus.ack) begin
                    ok = 1;
                    break;
                end
            end
            check("b2b_ack", ok, 1);
        end
        bus.req = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_ack_cnt", ack_cnt, 4);
        check("b2b_we_cnt", we_cnt, 3);
        check("b2b_last_mask", we_mask, 4'b1000);
        check("b2b_last_wd", last_wd, 8'h02);
        check("b2b_rd", bus.rd_data, 8'h3C);
        check("b2b_idle", bus.busy, 0);
        check("we_onehot", multi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gpio_io_controller.md
Name: gpio_io_controller

Overview:
Sequences CPU I/O-space accesses (IN, OUT, SBI, CBI) onto the gpio register block, which holds DDRA, PORTA, PINA, DDRB, PORTB and PINB.
- Decodes the 6-bit I/O address and drives a shared write-data bus plus one-hot write enables into gpio.
- Returns read data for IN.
- Performs the read-modify-write for single-bit set/clear.
- Sits between the CPU execute stage and gpio, on the same clock.

Parameters:
ADDR_PINB, 6'h16, I/O address of PINB
ADDR_DDRB, 6'h17, I/O address of DDRB
ADDR_PORTB, 6'h18, I/O address of PORTB
ADDR_PINA, 6'h19, I/O address of PINA
ADDR_DDRA, 6'h1A, I/O address of DDRA
ADDR_PORTA, 6'h1B, I/O address of PORTA

Ports:
clk  input  1  system clock, rising edge
clr_n  input  1  asynchronous active-low reset
req  input  1  transaction request, level, sampled only in IDLE
op  input  2  00=IN, 01=OUT, 10=SBI, 11=CBI
io_addr  input  6  I/O register address
wr_data  input  8  OUT data
bit_sel  input  3  bit index for SBI/CBI
busy  output  1  high in every state except IDLE
ack  output  1  one-cycle completion pulse
addr_err  output  1  valid with ack; address unmapped
rd_data  output  8  IN result, held until the next IN completes
gpio_wdata  output  8  shared write data to gpio
DDRA_we, PORTA_we, DDRB_we, PORTB_we  output  1 each  gpio write enables
DDRA_q, PORTA_q, PINA_q, DDRB_q, PORTB_q, PINB_q  input  8 each  gpio register outputs

Behaviour:
- Reset (async, clr_n=0): state=IDLE; busy, ack, addr_err, all *_we = 0; rd_data=8'h00; gpio_wdata=8'h00; latched request fields cleared. Applies mid-transaction; no write enable may be asserted after clr_n falls.
- States: IDLE, EXEC, RMW, DONE.
- IDLE: on req=1, latch op/io_addr/wr_data/bit_sel, clear addr_err, go EXEC. req=0: stay.
- EXEC, address decode:
  - Address is mapped only if equal to one of the six parameters.
  - Unmapped: no write enable, set addr_err, go DONE; rd_data unchanged.
  - IN: rd_data <= selected *_q, go DONE.
  - OUT: gpio_wdata=latched wr_data; assert the matching *_we for this cycle only; go DONE.
  - SBI/CBI: capture selected *_q into tmp; go RMW.
- RMW: gpio_wdata = tmp | (1<<bit_sel) for SBI, tmp & ~(1<<bit_sel) for CBI; assert matching *_we for this cycle only; go DONE.
- Writes to PINA/PINB (OUT, SBI, CBI): PINx is read-only. No write enable is asserted, addr_err=0, transaction acks normally.
- DONE: ack=1 for exactly this cycle, busy=1; go IDLE.
- Write enables and gpio_wdata are Moore outputs decoded from state and latched registers only; no combinational path from req/op/io_addr.
- Latency, counted in edges from the edge that samples req in IDLE:
  - IN/OUT: ack high after edge 2.
  - SBI/CBI: ack high after edge 3.
  - Write enable high after edge 1 (OUT) or edge 2 (SBI/CBI).
- Handshake: inputs are ignored while busy=1. The requester holds op/io_addr/wr_data/bit_sel only for the sampling edge. The requester must drop req in the cycle after ack, or it is taken as a new request.
- At most one *_we is high in any cycle; none is high outside EXEC/RMW.

Test Plan:
- Reset mid-SBI: assert clr_n=0 during RMW -> all *_we=0 immediately, busy=0, rd_data=00, state IDLE.
- OUT 0x1B data 0xA5 -> PORTA_we=1 for exactly one cycle with gpio_wdata=A5; ack 2 edges after sampling; addr_err=0.
- PINA_q=0x3C, IN 0x19 -> rd_data=3C with ack; no *_we pulses; rd_data holds 3C through a following OUT.
- PORTB_q=0x0F:
  - SBI 0x18 bit 7 -> PORTB_we with gpio_wdata=8F.
  - Then PORTB_q=8F, CBI bit 0 -> gpio_wdata=8E; ack 3 edges after sampling.
- IN 0x20 (unmapped) -> ack with addr_err=1, rd_data unchanged, no *_we. Then OUT 0x16 -> ack, addr_err=0, no *_we.
- req held high continuously with alternating ops -> back-to-back transactions, one ack per transaction. Changing inputs while busy has no effect.
